// File: rtl/kb_event_decoder_pkg.sv
// kb_pkg: shared definitions for the keyboard event decoder.
//  - PS/2 set-2 scan codes for the 12 game keys, plus the E0 (extended)
//    and F0 (break) prefix bytes
//  - key index enum, which is also the bit position in the held bitmap
//  - parser state encoding
//  - key_decode(): maps a scan byte to a one-hot key mask
package kb_pkg;

  localparam int NUM_KEYS = 12;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BACK  = 8'h66;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ESC   = 8'h76;
  localparam logic [7:0] PFX_EXT  = 8'hE0;
  localparam logic [7:0] PFX_BRK  = 8'hF0;

  typedef enum logic [3:0] {
    K_W     = 4'd0,
    K_A     = 4'd1,
    K_S     = 4'd2,
    K_D     = 4'd3,
    K_UP    = 4'd4,
    K_LEFT  = 4'd5,
    K_DOWN  = 4'd6,
    K_RIGHT = 4'd7,
    K_SPACE = 4'd8,
    K_ENTER = 4'd9,
    K_BACK  = 4'd10,
    K_ESC   = 4'd11
  } key_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } pstate_e;

  // One-hot key mask for a scan byte; zero for unmapped codes.
  // Arrows need the E0 prefix unless arrow_ext is cleared.
  function automatic logic [NUM_KEYS-1:0] key_decode(input logic [7:0] code,
                                                     input logic       ext,
                                                     input logic       arrow_ext);
    logic [NUM_KEYS-1:0] m;
    logic                arrow_ok;
    m        = '0;
    arrow_ok = ext | ~arrow_ext;
    case (code)
      SC_W:     m[K_W]     = 1'b1;
      SC_A:     m[K_A]     = 1'b1;
      SC_S:     m[K_S]     = 1'b1;
      SC_D:     m[K_D]     = 1'b1;
      SC_UP:    m[K_UP]    = arrow_ok;
      SC_LEFT:  m[K_LEFT]  = arrow_ok;
      SC_DOWN:  m[K_DOWN]  = arrow_ok;
      SC_RIGHT: m[K_RIGHT] = arrow_ok;
      SC_SPACE: m[K_SPACE] = 1'b1;
      SC_ENTER: m[K_ENTER] = 1'b1;
      SC_BACK:  m[K_BACK]  = 1'b1;
      SC_ESC:   m[K_ESC]   = 1'b1;
      default:  m          = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/kb_repeat_timer.sv
// kb_repeat_timer: auto-repeat tick generator for one player's direction keys.
//  clk, rst   : clock, synchronous active-high reset
//  any_held   : some direction key of this player is held (after this cycle's byte)
//  new_press  : a direction key of this player went 0->1 this cycle
//  tick       : combinational; high on a new press, and on each repeat expiry
//               (DELAY_CYC after the press, then every PERIOD_CYC)
module kb_repeat_timer #(
  parameter int DELAY_CYC  = 25_000_000,
  parameter int PERIOD_CYC = 10_000_000,
  parameter int CNT_W      = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic any_held,
  input  logic new_press,
  output logic tick
);

  localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] PERIOD_LD = CNT_W'(PERIOD_CYC - 1);

  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    tick    = 1'b0;
    if (new_press) begin
      // a fresh press always restarts the initial delay
      tick    = 1'b1;
      cnt_nxt = DELAY_LD;
    end else if (any_held) begin
      if (cnt != '0) begin
        cnt_nxt = cnt - 1'b1;
      end else begin
        tick    = 1'b1;
        cnt_nxt = PERIOD_LD;
      end
    end else begin
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

endmodule

// File: rtl/kb_event_decoder.sv
// kb_event_decoder: PS/2 scan-byte stream -> held-key bitmap, press pulses and
// auto-repeat direction ticks for two players.
//  clk, rst            : clock, synchronous active-high reset
//  din, din_valid      : scan byte and its one-cycle strobe
//  dir1_held/dir2_held : {W,A,S,D} / {UP,LEFT,DOWN,RIGHT} held levels
//  dir1_tick/dir2_tick : held levels gated by the player's repeat tick
//  choose, esc_pause   : ENTER press pulse
//  nxtcolor, pause     : SPACE press pulse
//  rechoose            : BACK press pulse
//  restart             : ESC press pulse
module kb_event_decoder
  import kb_pkg::*;
#(
  parameter int DELAY_CYC  = 25_000_000,
  parameter int PERIOD_CYC = 10_000_000,
  parameter int CNT_W      = 25,
  parameter int ARROW_EXT  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic [3:0] dir1_held,
  output logic [3:0] dir2_held,
  output logic [3:0] dir1_tick,
  output logic [3:0] dir2_tick,
  output logic       choose,
  output logic       esc_pause,
  output logic       nxtcolor,
  output logic       pause,
  output logic       rechoose,
  output logic       restart
);

  pstate_e state, state_nxt;
  logic    do_make, do_brk, cur_ext;
  logic    is_pfx;

  logic [NUM_KEYS-1:0] held, held_nxt, key_hit, make_mask, brk_mask, press;
  logic                tick1, tick2;

  assign is_pfx = (din == PFX_EXT) || (din == PFX_BRK);

  // ---------------- prefix parser ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_make   = 1'b0;
    do_brk    = 1'b0;
    cur_ext   = 1'b0;
    if (din_valid) begin
      case (state)
        ST_IDLE: begin
          if      (din == PFX_EXT) state_nxt = ST_EXT;
          else if (din == PFX_BRK) state_nxt = ST_BRK;
          else                     do_make   = 1'b1;
        end
        ST_EXT: begin
          // repeated E0 is tolerated and keeps the extended context
          if      (din == PFX_BRK) state_nxt = ST_EXT_BRK;
          else if (din == PFX_EXT) state_nxt = ST_EXT;
          else begin
            do_make   = 1'b1;
            cur_ext   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          // a prefix after F0 is malformed: drop the whole sequence
          state_nxt = ST_IDLE;
          do_brk    = ~is_pfx;
        end
        ST_EXT_BRK: begin
          state_nxt = ST_IDLE;
          do_brk    = ~is_pfx;
          cur_ext   = 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // ---------------- held bitmap ----------------
  assign key_hit   = key_decode(din, cur_ext, ARROW_EXT != 0);
  assign make_mask = do_make ? key_hit : '0;
  assign brk_mask  = do_brk  ? key_hit : '0;
  assign held_nxt  = (held | make_mask) & ~brk_mask;
  // typematic re-makes of a held key are not presses
  assign press     = make_mask & ~held;

  // ---------------- repeat timers ----------------
  kb_repeat_timer #(
    .DELAY_CYC (DELAY_CYC),
    .PERIOD_CYC(PERIOD_CYC),
    .CNT_W     (CNT_W)
  ) u_rep1 (
    .clk      (clk),
    .rst      (rst),
    .any_held (|held_nxt[K_D:K_W]),
    .new_press(|press[K_D:K_W]),
    .tick     (tick1)
  );

  kb_repeat_timer #(
    .DELAY_CYC (DELAY_CYC),
    .PERIOD_CYC(PERIOD_CYC),
    .CNT_W     (CNT_W)
  ) u_rep2 (
    .clk      (clk),
    .rst      (rst),
    .any_held (|held_nxt[K_RIGHT:K_UP]),
    .new_press(|press[K_RIGHT:K_UP]),
    .tick     (tick2)
  );

  // ---------------- registered outputs ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      held      <= '0;
      dir1_tick <= '0;
      dir2_tick <= '0;
      choose    <= 1'b0;
      esc_pause <= 1'b0;
      nxtcolor  <= 1'b0;
      pause     <= 1'b0;
      rechoose  <= 1'b0;
      restart   <= 1'b0;
    end else begin
      held      <= held_nxt;
      dir1_tick <= {held_nxt[K_W], held_nxt[K_A], held_nxt[K_S], held_nxt[K_D]} & {4{tick1}};
      dir2_tick <= {held_nxt[K_UP], held_nxt[K_LEFT], held_nxt[K_DOWN], held_nxt[K_RIGHT]}
                   & {4{tick2}};
      choose    <= press[K_ENTER];
      esc_pause <= press[K_ENTER];
      nxtcolor  <= press[K_SPACE];
      pause     <= press[K_SPACE];
      rechoose  <= press[K_BACK];
      restart   <= press[K_ESC];
    end
  end

  // held levels come straight from the bitmap register
  assign dir1_held = {held[K_W], held[K_A], held[K_S], held[K_D]};
  assign dir2_held = {held[K_UP], held[K_LEFT], held[K_DOWN], held[K_RIGHT]};

endmodule

// File: tb/tb_kb_event_decoder.sv
// Bench for kb_event_decoder: two instances (arrows need E0 / arrows accepted
// bare) share one byte stream. A reference model computes the expected
// outputs per cycle and queues them; a monitor pops and compares.
module tb_kb_event_decoder;

  localparam int DLY = 5;
  localparam int PER = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;

  logic [3:0] d1h [2], d2h [2], d1t [2], d2t [2];
  logic       cho [2], esc [2], nxt [2], pau [2], rch [2], rst_o [2];

  always #5 clk = ~clk;

  kb_event_decoder #(.DELAY_CYC(DLY), .PERIOD_CYC(PER), .CNT_W(4), .ARROW_EXT(1)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .dir1_held(d1h[0]), .dir2_held(d2h[0]), .dir1_tick(d1t[0]), .dir2_tick(d2t[0]),
    .choose(cho[0]), .esc_pause(esc[0]), .nxtcolor(nxt[0]), .pause(pau[0]),
    .rechoose(rch[0]), .restart(rst_o[0]));

  kb_event_decoder #(.DELAY_CYC(DLY), .PERIOD_CYC(PER), .CNT_W(4), .ARROW_EXT(0)) dut_bare (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .dir1_held(d1h[1]), .dir2_held(d2h[1]), .dir1_tick(d1t[1]), .dir2_tick(d2t[1]),
    .choose(cho[1]), .esc_pause(esc[1]), .nxtcolor(nxt[1]), .pause(pau[1]),
    .rechoose(rch[1]), .restart(rst_o[1]));

  // ---------------- reference model ----------------
  // Key order: W A S D UP LEFT DOWN RIGHT SPACE ENTER BACK ESC
  bit m_held [2][12];
  bit m_ext  [2];
  bit m_brk  [2];
  int m_age  [2][2];

  function automatic int key_of(input logic [7:0] b, input bit ext, input bit arrows_need_ext);
    bit ok;
    ok = ext || !arrows_need_ext;
    case (b)
      8'h1D: return 0;
      8'h1C: return 1;
      8'h1B: return 2;
      8'h23: return 3;
      8'h75: return ok ? 4 : -1;
      8'h6B: return ok ? 5 : -1;
      8'h72: return ok ? 6 : -1;
      8'h74: return ok ? 7 : -1;
      8'h29: return 8;
      8'h5A: return 9;
      8'h66: return 10;
      8'h76: return 11;
      default: return -1;
    endcase
  endfunction

  // Expected packing: {dir1_held, dir2_held, dir1_tick, dir2_tick,
  //                    choose, esc_pause, nxtcolor, pause, rechoose, restart}
  task automatic model_step(input int k, input bit r, input bit v, input logic [7:0] b,
                            output logic [21:0] e);
    bit pressed [12];
    bit tick [2];
    int key;
    logic [3:0] h [2];
    for (int i = 0; i < 12; i++) pressed[i] = 0;
    if (r) begin
      for (int i = 0; i < 12; i++) m_held[k][i] = 0;
      m_ext[k] = 0; m_brk[k] = 0;
      m_age[k][0] = 0; m_age[k][1] = 0;
      e = '0;
      return;
    end
    if (v) begin
      if (b == 8'hE0) begin
        if (m_brk[k]) begin m_brk[k] = 0; m_ext[k] = 0; end
        else m_ext[k] = 1;
      end else if (b == 8'hF0) begin
        if (m_brk[k]) begin m_brk[k] = 0; m_ext[k] = 0; end
        else m_brk[k] = 1;
      end else begin
        key = key_of(b, m_ext[k], k == 0);
        if (key >= 0) begin
          if (m_brk[k]) m_held[k][key] = 0;
          else begin
            if (!m_held[k][key]) pressed[key] = 1;
            m_held[k][key] = 1;
          end
        end
        m_ext[k] = 0; m_brk[k] = 0;
      end
    end
    for (int p = 0; p < 2; p++) begin
      bit any_p, any_h;
      any_p = 0; any_h = 0;
      for (int j = 0; j < 4; j++) begin
        any_p |= pressed[p*4+j];
        any_h |= m_held[k][p*4+j];
      end
      tick[p] = 0;
      if (any_p) begin
        m_age[k][p] = 0;
        tick[p] = 1;
      end else if (any_h) begin
        m_age[k][p]++;
        tick[p] = (m_age[k][p] == DLY) ||
                  (m_age[k][p] > DLY && ((m_age[k][p] - DLY) % PER) == 0);
      end else begin
        m_age[k][p] = 0;
      end
      for (int j = 0; j < 4; j++) h[p][3-j] = m_held[k][p*4+j];
    end
    e = {h[0], h[1], h[0] & {4{tick[0]}}, h[1] & {4{tick[1]}},
         pressed[9], pressed[9], pressed[8], pressed[8], pressed[10], pressed[11]};
  endtask

  // ---------------- scoreboard ----------------
  logic [43:0] sbq [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic cycle(input bit r, input bit v, input logic [7:0] b);
    logic [21:0] e0, e1;
    @(negedge clk);
    rst = r; din_valid = v; din = b;
    model_step(0, r, v, b, e0);
    model_step(1, r, v, b, e1);
    sbq.push_back({e0, e1});
  endtask

  task automatic send(input logic [7:0] b);
    cycle(0, 1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 8'h00);
  endtask

  always @(posedge clk) begin
    if (sbq.size() > 0) begin
      logic [43:0] ex;
      logic [21:0] got;
      ex = sbq.pop_front();
      #2;
      cyc++;
      for (int k = 0; k < 2; k++) begin
        got = {d1h[k], d2h[k], d1t[k], d2t[k], cho[k], esc[k], nxt[k], pau[k], rch[k], rst_o[k]};
        checks++;
        if (got !== (k == 0 ? ex[43:22] : ex[21:0])) begin
          errors++;
          if (errors <= 30)
            $display("FAIL outputs inst%0d cyc=%0d got=%h expected=%h", k, cyc, got,
                     (k == 0 ? ex[43:22] : ex[21:0]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] codes [14];

  initial begin
    codes = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74,
              8'h5A, 8'h66, 8'h29, 8'h76, 8'hE0, 8'hF0};

    cycle(1, 0, 8'h00); cycle(1, 1, 8'h1D); cycle(1, 0, 8'h00);
    idle(2);

    // W make then break
    send(8'h1D); idle(3); send(8'hF0); send(8'h1D); idle(2);
    // extended UP held for a while, then released
    send(8'hE0); send(8'h75); idle(20);
    send(8'hE0); send(8'hF0); send(8'h75); idle(5);
    // bare UP: ignored by one instance, a press for the other
    send(8'h75); idle(2); send(8'hF0); send(8'h75); idle(2);
    // typematic SPACE, then ENTER
    send(8'h29); send(8'h29); send(8'h29); send(8'hF0); send(8'h29);
    send(8'h5A); send(8'hF0); send(8'h5A); idle(2);
    // malformed break, then ESC as a make
    send(8'hF0); send(8'hE0); send(8'h76); idle(1); send(8'hF0); send(8'h76);
    // BACK
    send(8'h66); send(8'hF0); send(8'h66);
    // reset mid-hold, concurrent with a prefix byte
    send(8'h1D); send(8'hE0); send(8'h75); idle(2);
    cycle(1, 1, 8'hF0); idle(2);
    // the discarded F0 must not turn the next byte into a break
    send(8'h1C); idle(3); send(8'hF0); send(8'h1C);
    // new press during a hold restarts the delay
    send(8'h1D); idle(4); send(8'h23); idle(10);
    send(8'hF0); send(8'h1D); idle(4); send(8'hF0); send(8'h23); idle(2);

    for (int i = 0; i < 3000; i++) begin
      int sel;
      if ($urandom_range(0, 299) == 0) begin
        cycle(1, $urandom_range(0, 1), codes[13]);
      end else if ($urandom_range(0, 2) == 0) begin
        sel = $urandom_range(0, 15);
        if (sel < 14) send(codes[sel]);
        else          send(8'($urandom));
      end else begin
        cycle(0, 0, 8'($urandom));
      end
    end

    idle(3);
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain remaining=%0d required=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
